ram_fill_ctrl: RTL and testbench
================================

// Module: ram_fill_ctrl
// PURPOSE
//  Write-side controller for the ram32x4 word store: accepts 4-bit words on a valid/ready stream and writes
//  them to consecutive RAM addresses, so the popcount datapath can later read them back by address.
//  Sits between the board input/loader logic and the ram32x4 write port (addr/din/w), replacing bench force-writes.
// PARAMETERS
//  AW     5   address width; RAM depth = 2**AW words
//  DW     4   data word width
// PORTS
//  clk         in   1    system clock, all logic on rising edge
//  reset       in   1    synchronous, active-high reset
//  start       in   1    level: begin fill session; must stay high until done, drop to re-arm
//  base_addr   in   AW   first RAM address, sampled in IDLE when start rises
//  len         in   AW+1 words to write, 0..2**AW, sampled with base_addr
//  in_valid    in   1    source has a word on in_data
//  in_data     in   DW   word to store
//  in_ready    out  1    controller accepts in_data this cycle
//  ram_addr    out  AW   to ram32x4 addr
//  ram_din     out  DW   to ram32x4 din
//  ram_w       out  1    to ram32x4 w (write strobe)
//  ram_dout    in   DW   from ram32x4 dout (used only with verify)
//  busy        out  1    high in any state except IDLE/DONE
//  done        out  1    high in DONE
//  words_done  out  AW+1 words written this session
//  err         out  1    sticky readback mismatch (0 without verify)
// BEHAVIOUR
//  States (shared enum): IDLE, WRITE, VFY_RD, VFY_CMP, DONE.
//  Reset: state=IDLE; in_ready=0, ram_w=0, ram_addr=0, ram_din=0, busy=0, done=0, words_done=0, err=0.
//  IDLE: start=1 -> latch base_addr into cur_addr, len into remaining, clear words_done/err;
//        ->DONE if len==0, else ->WRITE.
//  WRITE: in_ready=1; ram_addr=cur_addr, ram_din=in_data, ram_w=in_valid (combinational, same cycle).
//        On in_valid: cur_addr+=1 mod 2**AW (wraps 2**AW-1 -> 0), remaining-=1, words_done+=1;
//        next = VFY_RD if verify, else DONE when remaining==1, else stay in WRITE. 1 word/cycle max, no bubbles.
//  RAM timing: write committed at the edge ending the ram_w cycle; dout valid 1 cycle after addr is presented.
//  DONE: done=1, ram_w=0, in_ready=0; start=0 -> IDLE. words_done/err hold until next session.
//  start dropping mid-session is ignored; the session runs to completion. Only reset aborts it.
//  Reset mid-session: IDLE next cycle; words already written stay in RAM; no partial write (ram_w=0 under reset).
//  in_ready never depends on in_valid (no combinational loop).
//  len > 2**AW is illegal; behaviour is writes wrapping and overwriting, with no error flagged.
// CONFIGURATION
//  `RAM_FILL_VERIFY_EN defined: after each accepted word, enter VFY_RD (ram_addr=written addr, ram_w=0, in_ready=0).
//    Then VFY_CMP compares ram_dout to the latched word; on mismatch set err (sticky) and latch err_addr (internal).
//    Then go to WRITE, or to DONE if remaining==0. Throughput is 1 word / 3 cycles.
//  Not defined: VFY_* states unreachable/removed, err tied 0, throughput is 1 word/cycle.
// STRUCTURE
//  ram_fill_pkg: state enum ram_fill_state_t {IDLE,WRITE,VFY_RD,VFY_CMP,DONE}, default AW/DW localparams.
//  Single module: FSM + address/length counters. ram32x4 is instantiated by the parent, not inside this block.
//  Bench wraps ram_fill_ctrl + ram32x4.
// TESTING
//  1 Reset hold 3 cycles -> all outputs 0, state IDLE; start ignored while reset=1.
//  2 base=0, len=32, in_data=i, valid every cycle -> 32 consecutive ram_w; RAM[i]==i;
//    done after 32 accepts; words_done=32.
//  3 base=30, len=4, data A,B,C,D -> RAM[30]=A, RAM[31]=B, RAM[0]=C, RAM[1]=D (wrap); RAM[2] untouched.
//  4 len=5 with in_valid toggled 1,0,0,1,... -> ram_w only on valid cycles; addresses stay contiguous.
//  5 len=0 -> DONE one cycle after start, no ram_w; start=0 -> IDLE; new session with len=1 works.
//  6 reset asserted after 3 of 8 writes -> IDLE, RAM[base..base+2] written, RAM[base+3] unchanged;
//    with RAM_FILL_VERIFY_EN, forcing ram_dout wrong once -> err=1 held through DONE.

Source files
------------

// File: rtl/ram_fill_pkg.sv
// Shared types and default sizes for the ram32x4 fill controller.
package ram_fill_pkg;

   localparam int unsigned RF_AW = 5;
   localparam int unsigned RF_DW = 4;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      VFY_RD,
      VFY_CMP,
      DONE
   } ram_fill_state_t;

endpackage

// File: rtl/ram_fill_ctrl.sv
// Streams valid/ready words into consecutive ram32x4 addresses starting at base_addr.
// Optional readback verify of every word is enabled with `RAM_FILL_VERIFY_EN.
module ram_fill_ctrl
   import ram_fill_pkg::*;
#(
   parameter int unsigned AW = RF_AW,
   parameter int unsigned DW = RF_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   len,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_w,
   input  logic [DW-1:0] ram_dout,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   words_done,
   output logic          err
);

   ram_fill_state_t state_q, state_d;
   logic [AW-1:0]   cur_addr_q, cur_addr_d;
   logic [AW:0]     remaining_q, remaining_d;
   logic [AW:0]     words_done_q, words_done_d;

`ifdef RAM_FILL_VERIFY_EN
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;
   logic [AW-1:0]   err_addr_q, err_addr_d;
   logic            err_q, err_d;
`else
   logic            unused_dout;
   assign unused_dout = ^ram_dout;
`endif

   // Next-state and RAM port decode; RAM port follows in_valid in the same cycle.
   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      remaining_d  = remaining_q;
      words_done_d = words_done_q;
`ifdef RAM_FILL_VERIFY_EN
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      err_addr_d   = err_addr_q;
      err_d        = err_q;
`endif
      in_ready     = 1'b0;
      ram_w        = 1'b0;
      ram_addr     = '0;
      ram_din      = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               cur_addr_d   = base_addr;
               remaining_d  = len;
               words_done_d = '0;
`ifdef RAM_FILL_VERIFY_EN
               err_d        = 1'b0;
`endif
               state_d      = (len == '0) ? DONE : WRITE;
            end
         end
         WRITE: begin
            in_ready = 1'b1;
            ram_addr = cur_addr_q;
            ram_din  = in_data;
            ram_w    = in_valid;
            if (in_valid) begin
               cur_addr_d   = cur_addr_q + AW'(1);
               remaining_d  = remaining_q - (AW+1)'(1);
               words_done_d = words_done_q + (AW+1)'(1);
`ifdef RAM_FILL_VERIFY_EN
               wr_addr_d    = cur_addr_q;
               wr_data_d    = in_data;
               state_d      = VFY_RD;
`else
               if (remaining_q == (AW+1)'(1)) state_d = DONE;
`endif
            end
         end
`ifdef RAM_FILL_VERIFY_EN
         VFY_RD: begin
            ram_addr = wr_addr_q;
            state_d  = VFY_CMP;
         end
         VFY_CMP: begin
            ram_addr = wr_addr_q;
            if (ram_dout != wr_data_q) begin
               err_d      = 1'b1;
               err_addr_d = wr_addr_q;
            end
            state_d = (remaining_q == '0) ? DONE : WRITE;
         end
`endif
         DONE: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // No partial write or handshake while reset is asserted.
      if (reset) begin
         in_ready = 1'b0;
         ram_w    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cur_addr_q   <= '0;
         remaining_q  <= '0;
         words_done_q <= '0;
`ifdef RAM_FILL_VERIFY_EN
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         err_addr_q   <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         remaining_q  <= remaining_d;
         words_done_q <= words_done_d;
`ifdef RAM_FILL_VERIFY_EN
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         err_addr_q   <= err_addr_d;
         err_q        <= err_d;
`endif
      end
   end

   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign done       = (state_q == DONE);
   assign words_done = words_done_q;
`ifdef RAM_FILL_VERIFY_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fill_ctrl.sv
// Bench: ram_fill_ctrl driving a behavioural ram32x4, checked against expected memory images.
module tb_ram_fill_ctrl;

   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 4;
   localparam int unsigned DEPTH = 32;
`ifdef RAM_FILL_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout;
   logic          ram_w, busy, done, err;
   logic [AW:0]   words_done;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] dout_q;
   logic          force_bad = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // ram32x4 model: write at the edge ending the ram_w cycle, registered read.
   always @(posedge clk) begin
      if (ram_w) mem[ram_addr] <= ram_din;
      dout_q <= mem[ram_addr];
   end
   assign ram_dout = dout_q ^ (force_bad ? DW'(1) : DW'(0));

   ram_fill_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_w(ram_w), .ram_dout(ram_dout),
      .busy(busy), .done(done), .words_done(words_done), .err(err)
   );

   // One fill session against an expected memory image built from base/len/data.
   task automatic run_session(input string name, input int base, input int n, input int vpct,
                              input bit seq_data, input bit corrupt);
      logic [DW-1:0] dq [64];
      logic [DW-1:0] exp_mem [DEPTH];
      int idx = 0, cyc = 0, first_acc = -1, bad_port = 0, bad_mem = 0, exp_cyc;
      bit got_done = 1'b0;
      for (int i = 0; i < 64; i++) dq[i] = seq_data ? DW'(i) : DW'($urandom);
      for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = mem[i];
      for (int i = 0; i < n; i++) exp_mem[(base + i) % DEPTH] = dq[i];

      @(negedge clk);
      base_addr = AW'(base);
      len       = (AW+1)'(n);
      start     = 1'b1;
      in_valid  = 1'b0;
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            got_done = 1'b1;
            break;
         end
         in_valid  = (idx < n) && ($urandom_range(99) < vpct);
         in_data   = (idx < n) ? dq[idx] : DW'($urandom);
         force_bad = corrupt && (first_acc >= 0) && (cyc == first_acc + 2);
         #1;
         if (ram_w !== (in_valid && in_ready)) bad_port++;
         if (ram_w && (ram_addr !== AW'(base + idx) || ram_din !== dq[idx])) bad_port++;
         if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            idx++;
         end
      end
      force_bad = 1'b0;
      in_valid  = 1'b0;

      checks++;
      if (!got_done) begin
         errors++;
         $display("FAIL %s timeout: done never rose, accepted %0d of %0d", name, idx, n);
      end
      checks++;
      if (bad_port != 0) begin
         errors++;
         $display("FAIL %s ram_port: %0d bad write cycles, required 0", name, bad_port);
      end
      checks++;
      if (idx != n || words_done !== (AW+1)'(n)) begin
         errors++;
         $display("FAIL %s count: accepted=%0d words_done=%0d, required %0d", name, idx, words_done, n);
      end
      if (vpct == 100 || n == 0) begin
         exp_cyc = (n == 0) ? 1 : (VERIFY ? 3 * n + 1 : n + 1);
         checks++;
         if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s latency: done at cycle %0d, required %0d", name, cyc, exp_cyc);
         end
      end
      for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== exp_mem[i]) bad_mem++;
      checks++;
      if (bad_mem != 0) begin
         errors++;
         $display("FAIL %s mem: %0d words differ from expected image, required 0", name, bad_mem);
      end
      checks++;
      if (err !== (VERIFY && corrupt) || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s status: err=%b busy=%b, required err=%b busy=0", name, err, busy, VERIFY && corrupt);
      end

      start = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || err !== (VERIFY && corrupt) || words_done !== (AW+1)'(n)) begin
         errors++;
         $display("FAIL %s rearm: done=%b busy=%b err=%b words_done=%0d, required 0 0 %b %0d",
                  name, done, busy, err, words_done, VERIFY && corrupt, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; base_addr = 5; len = 6'd4; in_valid = 1'b1; in_data = 4'h9;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({in_ready, ram_w, ram_addr, ram_din, busy, done, words_done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b w=%b a=%0d d=%0d busy=%b done=%b wd=%0d err=%b, required all 0",
                     in_ready, ram_w, ram_addr, ram_din, busy, done, words_done, err);
         end
      end
      @(negedge clk);
      reset = 1'b0; start = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] exp_mem [DEPTH];
      int base = int'($urandom_range(DEPTH - 1));
      int idx = 0, cyc = 0, bad_mem = 0;
      logic [DW-1:0] d;
      for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = mem[i];
      @(negedge clk);
      base_addr = AW'(base); len = 6'd8; start = 1'b1; in_valid = 1'b0;
      while (idx < 3 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         d = DW'($urandom);
         in_valid = 1'b1; in_data = d;
         #1;
         if (in_ready) begin
            exp_mem[(base + idx) % DEPTH] = d;
            idx++;
         end
      end
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b1; in_data = ~mem[(base + 3) % DEPTH];
      #1;
      checks++;
      if (ram_w !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_write: ram_w=%b in_ready=%b under reset, required 0 0", ram_w, in_ready);
      end
      @(negedge clk);
      reset = 1'b0; start = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || words_done !== '0) begin
         errors++;
         $display("FAIL reset_mid_idle: busy=%b done=%b rdy=%b wd=%0d, required 0 0 0 0",
                  busy, done, in_ready, words_done);
      end
      for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== exp_mem[i]) bad_mem++;
      checks++;
      if (idx != 3 || bad_mem != 0) begin
         errors++;
         $display("FAIL reset_mid_mem: accepted=%0d bad_words=%0d, required 3 0", idx, bad_mem);
      end
   endtask

   task automatic test_full_fill();   run_session("full_fill", 0, 32, 100, 1'b1, 1'b0); endtask
   task automatic test_wrap();        run_session("wrap", 30, 4, 100, 1'b0, 1'b0); endtask
   task automatic test_gaps();        run_session("gaps", 7, 5, 40, 1'b0, 1'b0); endtask

   task automatic test_len_zero();
      run_session("len_zero", 12, 0, 100, 1'b0, 1'b0);
      run_session("len_one", 12, 1, 100, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int s = 0; s < 4; s++)
         run_session("random", int'($urandom_range(DEPTH - 1)), int'($urandom_range(1, DEPTH)),
                     int'($urandom_range(30, 100)), 1'b0, 1'b0);
   endtask

   task automatic test_verify_err();
      run_session("verify_err", 3, 3, 100, 1'b0, VERIFY);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; in_valid = 1'b0; in_data = '0;
      test_reset();
      test_full_fill();
      test_wrap();
      test_gaps();
      test_len_zero();
      test_reset_mid();
      test_random();
      test_verify_err();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
